stream_rr_arbiter: RTL and testbench

//  - Merges N valid/ready generator streams onto one downstream valid/ready channel.
//  - Arbitration is round-robin. A winner keeps the grant for BURST accepted beats.
//  - Sits between several generator_logic-style sources and a single sink or tracker.
//  - Zero-latency mux path: a beat reaches the output in the same cycle it is offered.

---
 rtl/stream_rr_arbiter_pkg.sv | 18 +
 rtl/stream_rr_arbiter_rr_pick.sv | 36 +++
 rtl/stream_rr_arbiter.sv | 112 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter: FSM state
// encodings and a constant clog2 used for index/counter widths.
package stream_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick. Returns the first asserted req
// at or after base, wrapping N-1 -> 0, via a doubled-vector priority scan.
module rr_pick
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;

  // Rotate req so base lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[base +: N];
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        pos   = int'(base) + j;
        if (pos >= N) pos = pos - N;
        idx   = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: merges N valid/ready streams onto one downstream
// channel. Round-robin pick; the winner holds the grant for BURST accepted
// beats. Zero-latency combinational mux from registered FSM state.
// Optional feature macro: STREAM_ARB_SRC_ID_EN adds the down_src port.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DW    = 16,
  parameter  int BURST = 4,
  localparam int IDW   = clog2(N),
  localparam int CW    = clog2(BURST) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_valid,
  output logic [N-1:0]    up_ready,
  input  logic [N*DW-1:0] up_data,
  input  logic            down_ready,
  output logic            down_valid,
  output logic [DW-1:0]   down_data
`ifdef STREAM_ARB_SRC_ID_EN
  ,
  output logic [IDW-1:0]  down_src
`endif
);

  state_t               state, state_nx;
  logic [IDW-1:0]       ptr, ptr_nx, grant, grant_nx, sel, cur;
  logic [CW-1:0]        beat_cnt, beat_nx;
  logic                 found, hs;
  logic [N-1:0][DW-1:0] data_arr;

  assign data_arr = up_data;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
    return (x == IDW'(N - 1)) ? '0 : x + IDW'(1);
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req  (up_valid),
    .base (ptr),
    .found(found),
    .idx  (sel)
  );

  // Output mux: IDLE follows the live pick, HOLD is pinned to the grant.
  always_comb begin
    up_ready   = '0;
    cur        = (state == ST_HOLD) ? grant : sel;
    down_valid = (state == ST_HOLD) ? up_valid[grant] : found;
    down_data  = down_valid ? data_arr[cur] : '0;
    if (state == ST_HOLD || found) up_ready[cur] = down_ready;
    hs         = down_valid && down_ready;
  end

`ifdef STREAM_ARB_SRC_ID_EN
  assign down_src = down_valid ? cur : '0;
`else
  // No source-index port in this build; cur only steers the data mux.
`endif

  // Next-state: a stalled IDLE offer still moves to HOLD so the chosen
  // source cannot be displaced while the sink is not ready.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant;
    beat_nx  = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          if (hs && BURST == 1) begin
            ptr_nx = wrap_inc(sel);
          end else begin
            state_nx = ST_HOLD;
            grant_nx = sel;
            beat_nx  = hs ? CW'(1) : '0;
          end
        end
      end
      ST_HOLD: begin
        if (hs) begin
          if (beat_cnt == CW'(BURST - 1)) begin
            state_nx = ST_IDLE;
            ptr_nx   = wrap_inc(grant);
            beat_nx  = '0;
          end else begin
            beat_nx  = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      grant    <= grant_nx;
      beat_cnt <= beat_nx;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_stream_rr_arbiter;
  localparam int N = 4, DW = 16, BURST = 4, IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    up_valid = '0;
  logic [N-1:0]    up_ready;
  logic [N*DW-1:0] up_data = '0;
  logic            down_ready = 1'b0;
  logic            down_valid;
  logic [DW-1:0]   down_data;
`ifdef STREAM_ARB_SRC_ID_EN
  logic [IDW-1:0]  down_src;
`endif

  stream_rr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .down_ready(down_ready), .down_valid(down_valid),
`ifdef STREAM_ARB_SRC_ID_EN
    .down_src(down_src),
`endif
    .down_data(down_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // stimulus state
  logic [N-1:0]  vld = '0;
  logic [DW-1:0] dat [N];
  logic          rdy = 1'b0, rst_v = 1'b1;

  // model: owner = -1 when no source holds the grant
  int m_owner = -1, m_ptr = 0, m_taken = 0;
  logic          e_found, e_valid;
  int            e_src;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_ready;

  // observations of the last tick
  logic          last_hs, cur_dv, prev_stall = 1'b0;
  int            last_src;
  logic [DW-1:0] last_data, prev_data;
  logic [N-1:0]  cur_ur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_found = 1'b0;
    e_src   = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (!e_found && vld[(m_ptr + k) % N]) begin
          e_found = 1'b1;
          e_src   = (m_ptr + k) % N;
        end
      e_valid = e_found;
    end else begin
      e_src   = m_owner;
      e_valid = vld[m_owner];
    end
    e_data  = e_valid ? dat[e_src] : '0;
    e_ready = '0;
    if (m_owner >= 0 || e_found) e_ready[e_src] = rdy;
  endtask

  task automatic model_step();
    logic hs;
    hs = e_valid && rdy;
    if (m_owner < 0) begin
      if (e_found) begin
        if (hs && BURST == 1) m_ptr = (e_src + 1) % N;
        else begin
          m_owner = e_src;
          m_taken = hs ? 1 : 0;
        end
      end
    end else if (hs) begin
      m_taken++;
      if (m_taken == BURST) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_taken = 0;
      end
    end
  endtask

  // One cycle: drive at negedge, compare against the model, advance at posedge.
  task automatic tick();
    @(negedge clk);
    rst        = rst_v;
    up_valid   = vld;
    down_ready = rdy;
    for (int i = 0; i < N; i++) up_data[i*DW +: DW] = dat[i];
    if (rst_v) begin
      m_owner = -1; m_ptr = 0; m_taken = 0;
    end
    #1;
    model_eval();
    chk("down_valid", down_valid, e_valid);
    chk("down_data", down_data, e_data);
    chk("up_ready", up_ready, e_ready);
`ifdef STREAM_ARB_SRC_ID_EN
    chk("down_src", down_src, e_valid ? e_src : 0);
`endif
    if (prev_stall && !rst_v) begin
      chk("hold_valid", down_valid, 1'b1);
      chk("hold_data", down_data, prev_data);
    end
    prev_stall = down_valid && !rdy && !rst_v;
    prev_data  = down_data;
    cur_dv     = down_valid;
    cur_ur     = up_ready;
    last_hs    = e_valid && rdy && !rst_v;
    last_src   = e_src;
    last_data  = down_data;
    @(posedge clk);
    if (!rst_v) model_step();
  endtask

  task automatic do_reset();
    rst_v = 1'b1; vld = '0; rdy = 1'b0;
    tick();
    rst_v = 1'b0;
  endtask

  int cnt [N];

  initial begin
    for (int i = 0; i < N; i++) dat[i] = DW'(16'hA000 + i);

    // reset with all requesting: requester 0 offered combinationally
    rst_v = 1'b1; vld = 4'b1111; rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_dv", cur_dv, 1'b1);
      chk("rst_data", last_data, 16'hA000);
    end

    // idle after reset
    rst_v = 1'b0; vld = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_dv", cur_dv, 1'b0);
      chk("idle_ur", cur_ur, 4'b0000);
    end

    // single source 2: full burst then immediate re-grant
    vld = 4'b0100; rdy = 1'b1; dat[2] = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("single_hs", last_hs, 1'b1);
      chk("single_data", last_data, 16'h0010 + k);
      chk("single_src", last_src, 2);
      dat[2] = dat[2] + 16'h1;
    end

    // all requesting: 4 beats each in order 0,1,2,3,0...
    do_reset();
    for (int i = 0; i < N; i++) begin
      dat[i] = DW'(i * 16'h0100);
      cnt[i] = 0;
    end
    vld = 4'b1111; rdy = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("rr_src", last_src, (k / 4) % 4);
      chk("rr_data", last_data, ((k / 4) % 4) * 16'h0100 + (k / 16) * 4 + (k % 4));
      cnt[last_src]++;
      dat[last_src] = dat[last_src] + 16'h1;
    end
    for (int i = 0; i < N; i++) chk("rr_count", cnt[i], 8);

    // backpressure freezes the src 1 offer
    do_reset();
    vld = 4'b0010; dat[1] = 16'h1111; dat[0] = 16'h0AAA; rdy = 1'b0;
    tick();
    chk("bp_first", last_data, 16'h1111);
    vld = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_freeze", last_data, 16'h1111);
      chk("bp_nohs", last_hs, 1'b0);
    end
    rdy = 1'b1;
    tick();
    chk("bp_release_hs", last_hs, 1'b1);
    chk("bp_release", last_data, 16'h1111);

    // granted source idles mid-burst
    do_reset();
    vld = 4'b0100; dat[2] = 16'h2000; rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      dat[2] = dat[2] + 16'h1;
    end
    vld = 4'b1000; dat[3] = 16'h3000;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("gap_dv", cur_dv, 1'b0);
      chk("gap_ur3", cur_ur[3], 1'b0);
    end
    vld = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("resume_data", last_data, 16'h2002 + k);
      dat[2] = dat[2] + 16'h1;
    end
    vld = 4'b1000;
    tick();
    chk("after_burst", last_data, 16'h3000);

    // reset mid-burst of src 1
    do_reset();
    vld = 4'b0010; dat[1] = 16'h1000; rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      dat[1] = dat[1] + 16'h1;
    end
    rst_v = 1'b1; vld = 4'b1011; dat[0] = 16'h0500; dat[3] = 16'h3300;
    tick();
    chk("midrst_data", last_data, 16'h0500);
    rst_v = 1'b0;
    tick();
    chk("midrst_src", last_src, 0);
    chk("midrst_hs", last_data, 16'h0500);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] || (last_hs && last_src == i)) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          dat[i] = DW'($urandom);
        end
      rdy   = ($urandom_range(0, 3) != 0);
      rst_v = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
